descrambler_sync: RTL and testbench

DESCRAMBLER_SYNC -- requirements
Module: descrambler_sync

---
 rtl/descrambler_sync.sv | 155 +++++++++++++++
 tb/tb_descrambler_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_sync.sv
// Self-synchronising receive descrambler for x^7+x^4+1: the first seven scrambled
// SERVICE bits seed the LFSR, then SERVICE bits 7..15 are checked and DATA is recovered.
module descrambler_sync #(
  parameter int PASS_SERVICE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_sof,
  input  logic       in_last,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic [7:1] lfsr_state,
  output logic       state_valid,
  output logic       service_err,
  output logic       short_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SYNC, SERVICE, DATA} state_t;

  localparam bit PassSvc = (PASS_SERVICE != 0);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:1] lfsr_q, lfsr_d;
  logic [7:1] lfsr_state_q, lfsr_state_d;
  logic       state_valid_q, state_valid_d;
  logic       service_err_q, service_err_d;
  logic       short_err_q, short_err_d;
  logic       out_valid_q, out_valid_d;
  logic       out_bit_q, out_bit_d;
  logic       out_last_q, out_last_d;

  logic       seq;
  logic       desc;
  logic [7:1] sync_shift;
  logic [7:1] advance;

  // Scrambled zeros equal the sequence itself, so during SYNC the raw bit is the next LFSR bit.
  assign seq        = lfsr_q[7] ^ lfsr_q[4];
  assign desc       = in_bit ^ seq;
  assign sync_shift = {lfsr_q[6:1], in_bit};
  assign advance    = {lfsr_q[6:1], seq};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    lfsr_state_d  = lfsr_state_q;
    state_valid_d = state_valid_q;
    service_err_d = service_err_q;
    short_err_d   = short_err_q;
    out_valid_d   = 1'b0;
    out_bit_d     = 1'b0;
    out_last_d    = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        state_d       = SYNC;
        cnt_d         = 4'd1;
        lfsr_d        = sync_shift;
        state_valid_d = 1'b0;
        service_err_d = 1'b0;
        short_err_d   = 1'b0;
        out_valid_d   = PassSvc;
        out_last_d    = PassSvc && in_last;
        if (in_last) begin
          short_err_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = 4'd0;
        end
      end else begin
        case (state_q)
          SYNC: begin
            lfsr_d      = sync_shift;
            out_valid_d = PassSvc;
            out_last_d  = PassSvc && in_last;
            cnt_d       = cnt_q + 4'd1;
            if (cnt_q == 4'd6) begin
              lfsr_state_d  = sync_shift;
              state_valid_d = 1'b1;
              state_d       = SERVICE;
            end
            if (in_last) begin
              short_err_d = 1'b1;
              state_d     = IDLE;
              cnt_d       = 4'd0;
            end
          end
          SERVICE: begin
            lfsr_d      = advance;
            out_valid_d = PassSvc;
            out_bit_d   = PassSvc && desc;
            out_last_d  = PassSvc && in_last;
            cnt_d       = cnt_q + 4'd1;
            if (desc) service_err_d = 1'b1;
            if (cnt_q == 4'd15) state_d = DATA;
            if (in_last) begin
              short_err_d = 1'b1;
              state_d     = IDLE;
              cnt_d       = 4'd0;
            end
          end
          DATA: begin
            lfsr_d      = advance;
            out_valid_d = 1'b1;
            out_bit_d   = desc;
            out_last_d  = in_last;
            if (in_last) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      lfsr_q        <= 7'd0;
      lfsr_state_q  <= 7'd0;
      state_valid_q <= 1'b0;
      service_err_q <= 1'b0;
      short_err_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      lfsr_state_q  <= lfsr_state_d;
      state_valid_q <= state_valid_d;
      service_err_q <= service_err_d;
      short_err_q   <= short_err_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      out_last_q    <= out_last_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_last    = out_last_q;
  assign lfsr_state  = lfsr_state_q;
  assign state_valid = state_valid_q;
  assign service_err = service_err_q;
  assign short_err   = short_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_descrambler_sync.sv
// Directed bench for descrambler_sync: one instance strips SERVICE, one passes it;
// frames are produced by a transmitter-side scrambler model seeded with 1011101.
module tb_descrambler_sync;

  logic       clk;
  logic       reset;
  logic       in_valid, in_bit, in_sof, in_last;

  logic       ov0, ob0, ol0, sv0, se0, sh0, busy0;
  logic [7:1] ls0;
  logic       ov1, ob1, ol1, sv1, se1, sh1, busy1;
  logic [7:1] ls1;

  int checks   = 0;
  int failures = 0;

  logic [23:0] txBits;
  logic [31:0] cap0, cap1;
  int          n0, n1, lastPos0, lastPos1;

  localparam logic [6:0] Seed    = 7'b1011101;
  localparam logic [7:1] SyncExp = 7'b0110110;
  localparam logic [7:0] DataA   = 8'b10110010;

  descrambler_sync #(.PASS_SERVICE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_last(in_last), .out_valid(ov0), .out_bit(ob0), .out_last(ol0), .lfsr_state(ls0),
    .state_valid(sv0), .service_err(se0), .short_err(sh0), .busy(busy0)
  );

  descrambler_sync #(.PASS_SERVICE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_last(in_last), .out_valid(ov1), .out_bit(ob1), .out_last(ol1), .lfsr_state(ls1),
    .state_valid(sv1), .service_err(se1), .short_err(sh1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Transmitter model: seed s7..s1, SERVICE bits 0..15 then DATA MSB first.
  task automatic buildFrame(input logic [6:0] seed, input logic [15:0] service, input logic [7:0] data);
    logic [6:0] s;
    logic       sq, d;
    s = seed;
    for (int i = 0; i < 24; i++) begin
      d = (i < 16) ? service[i] : data[23 - i];
      sq = s[6] ^ s[3];
      txBits[i] = d ^ sq;
      s = {s[5:0], sq};
    end
  endtask

  task automatic clearCapture();
    cap0 = 0; cap1 = 0; n0 = 0; n1 = 0; lastPos0 = -1; lastPos1 = -1;
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic sof, input logic last);
    in_valid = v; in_bit = b; in_sof = sof; in_last = last;
    @(posedge clk);
    #1;
    if (ov0) begin
      cap0 = {cap0[30:0], ob0};
      if (ol0) lastPos0 = n0;
      n0++;
    end
    if (ov1) begin
      cap1 = {cap1[30:0], ob1};
      if (ol1) lastPos1 = n1;
      n1++;
    end
    if (!v) begin
      checkOutput("idle_ov0", 32'(ov0), 32'd0);
      checkOutput("idle_ov1", 32'(ov1), 32'd0);
    end
  endtask

  task automatic sendFrame(input int count, input bit withLast, input bit gaps);
    clearCapture();
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        int g;
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, txBits[i], i == 0, withLast && (i == count - 1));
      if (count > 7 && i == 5) checkOutput("sv_before_sync", 32'(sv0), 32'd0);
      if (count > 7 && i == 6) begin
        checkOutput("sv_at_sync", 32'(sv0), 32'd1);
        checkOutput("lfsr_at_sync", 32'(ls0), 32'(SyncExp));
      end
    end
    in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0; in_bit = 1'b0;
  endtask

  task automatic checkGoodFrame(input logic [23:0] passExp);
    checkOutput("data_bits", cap0[7:0], 32'(DataA));
    checkOutput("data_count", n0, 8);
    checkOutput("data_last", lastPos0, 7);
    checkOutput("pass_bits", cap1[23:0], 32'(passExp));
    checkOutput("pass_count", n1, 24);
    checkOutput("pass_last", lastPos1, 23);
    checkOutput("end_busy", 32'(busy0), 32'd0);
    checkOutput("end_short", 32'(sh0), 32'd0);
    checkOutput("end_lfsr", 32'(ls0), 32'(SyncExp));
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; in_last = 1'b0;
    clearCapture();
    #3;
    checkOutput("reset_outs0", {ov0, ob0, ol0, sv0, se0, sh0, busy0, ls0}, 32'd0);
    checkOutput("reset_outs1", {ov1, ob1, ol1, sv1, se1, sh1, busy1, ls1}, 32'd0);
    #20 reset = 1'b1;

    $display("[TB] idle bits without sof are ignored");
    clearCapture();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_ignore_n0", n0, 0);
    checkOutput("idle_ignore_n1", n1, 0);
    checkOutput("idle_ignore_busy", 32'(busy0), 32'd0);

    $display("[TB] clean frame");
    buildFrame(Seed, 16'h0000, DataA);
    checkOutput("first7_rx", txBits[6:0], 32'b0110110);
    sendFrame(24, 1'b1, 1'b0);
    checkGoodFrame(24'h0000B2);
    checkOutput("clean_serr", 32'(se0), 32'd0);
    checkOutput("clean_sv", 32'(sv0), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] SERVICE bit 9 flipped");
    buildFrame(Seed, 16'h0200, DataA);
    sendFrame(24, 1'b1, 1'b0);
    checkOutput("svcerr_data", cap0[7:0], 32'(DataA));
    checkOutput("svcerr_pass", cap1[23:0], 32'h0040B2);
    checkOutput("svcerr_flag", 32'(se0), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("svcerr_sticky", 32'(se0), 32'd1);
    checkOutput("svcerr_sticky1", 32'(se1), 32'd1);

    $display("[TB] clean frame with input gaps");
    buildFrame(Seed, 16'h0000, DataA);
    sendFrame(24, 1'b1, 1'b1);
    checkGoodFrame(24'h0000B2);
    checkOutput("gaps_serr_cleared", 32'(se0), 32'd0);

    $display("[TB] in_last at SERVICE bit 10");
    sendFrame(11, 1'b1, 1'b0);
    checkOutput("short_flag0", 32'(sh0), 32'd1);
    checkOutput("short_busy", 32'(busy0), 32'd0);
    checkOutput("short_n0", n0, 0);
    checkOutput("short_n1", n1, 11);
    checkOutput("short_last1", lastPos1, 10);
    checkOutput("short_flag1", 32'(sh1), 32'd1);

    $display("[TB] sof reasserted at DATA bit 3");
    sendFrame(19, 1'b0, 1'b0);
    checkOutput("abandon_n0", n0, 3);
    checkOutput("abandon_bits", cap0[2:0], 32'b101);
    checkOutput("abandon_busy", 32'(busy0), 32'd1);
    sendFrame(24, 1'b1, 1'b0);
    checkOutput("abandon_short_cleared", 32'(sh0), 32'd0);
    checkGoodFrame(24'h0000B2);

    $display("[TB] one-bit frame");
    sendFrame(1, 1'b1, 1'b0);
    checkOutput("one_short", 32'(sh0), 32'd1);
    checkOutput("one_sv", 32'(sv0), 32'd0);
    checkOutput("one_busy", 32'(busy0), 32'd0);
    checkOutput("one_n0", n0, 0);
    checkOutput("one_n1", n1, 1);
    checkOutput("one_last1", lastPos1, 0);

    $display("[TB] reset during SERVICE");
    sendFrame(12, 1'b0, 1'b0);
    checkOutput("pre_reset_busy", 32'(busy0), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_outs0", {ov0, ob0, ol0, sv0, se0, sh0, busy0, ls0}, 32'd0);
    checkOutput("midreset_outs1", {ov1, ob1, ol1, sv1, se1, sh1, busy1, ls1}, 32'd0);
    #14 reset = 1'b1;
    clearCapture();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, txBits[12 + i], 1'b0, 1'b0);
    checkOutput("post_reset_n0", n0, 0);
    checkOutput("post_reset_n1", n1, 0);
    checkOutput("post_reset_busy", 32'(busy0), 32'd0);
    sendFrame(24, 1'b1, 1'b0);
    checkGoodFrame(24'h0000B2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
